// File: rtl/modo16_pkg.sv
// Shared definitions for the MODO_16bit counter and its checker.
// Mode encodings plus the checker FSM state type.
package modo16_pkg;

   localparam logic [1:0] MODO_UP  = 2'b00;
   localparam logic [1:0] MODO_DN  = 2'b01;
   localparam logic [1:0] MODO_DN3 = 2'b10;
   localparam logic [1:0] MODO_LD  = 2'b11;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } chk_state_t;

endpackage

// File: rtl/modo16_model.sv
// Combinational next-state function of the MODO_16bit counter.
// Shared by the checker and any future golden-value generator.
module modo16_model
   import modo16_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_q,
   input  logic             i_enable,
   input  logic [1:0]       i_modo,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q_n,
   output logic             o_rco_n
);

   always_comb begin
      o_q_n   = i_q;
      o_rco_n = 1'b0;
      if (i_enable) begin
         unique case (i_modo)
            MODO_UP: begin
               o_q_n   = i_q + WIDTH'(1);
               o_rco_n = (i_q == '1);
            end
            MODO_DN: begin
               o_q_n   = i_q - WIDTH'(1);
               o_rco_n = (i_q == '0);
            end
            MODO_DN3: begin
               // borrow whenever fewer than three counts remain
               o_q_n   = i_q - WIDTH'(3);
               o_rco_n = (i_q < WIDTH'(3));
            end
            MODO_LD: begin
               o_q_n   = i_d;
               o_rco_n = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/modo16bits_checker.sv
// Cycle-accurate monitor for the MODO_16bit counter.
// Tracks its own model and flags each q/rco mismatch.
module modo16bits_checker
   import modo16_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int ERRW    = 8,
   parameter int MAX_ERR = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             chk_en,
   input  logic             enable,
   input  logic [1:0]       modo,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] q,
   input  logic             rco,
   output logic             err,
   output logic             err_sticky,
   output logic [ERRW-1:0]  err_cnt,
   output logic [WIDTH-1:0] first_exp,
   output logic [WIDTH-1:0] first_got,
   output logic             halted
);

   localparam logic [ERRW-1:0] ERR_SAT = '1;
   localparam logic [ERRW-1:0] MAX_V   = ERRW'(MAX_ERR);

   chk_state_t       r_state;
   chk_state_t       w_state_n;
   logic [WIDTH-1:0] r_exp_q;
   logic             r_exp_rco;
   logic [WIDTH-1:0] w_q_n;
   logic             w_rco_n;
   logic             w_mis;
   logic             w_live;
   logic             w_hit;
   logic [ERRW-1:0]  w_cnt_inc;

   modo16_model #(
      .WIDTH (WIDTH)
   ) u_model (
      .i_q      (r_exp_q),
      .i_enable (enable),
      .i_modo   (modo),
      .i_d      (d),
      .o_q_n    (w_q_n),
      .o_rco_n  (w_rco_n)
   );

   // compare against pre-edge values: zero latency vs the DUT register
   assign w_mis  = (q != r_exp_q) | (rco != r_exp_rco);
   assign w_live = (r_state != ST_HALT);
   assign w_hit  = chk_en & w_live & w_mis;

   assign w_cnt_inc = (err_cnt == ERR_SAT) ? err_cnt
                                           : err_cnt + ERRW'(1);

   always_comb begin
      w_state_n = r_state;
      unique case (r_state)
         ST_INIT: begin
            w_state_n = ST_RUN;
            if (w_hit && (w_cnt_inc >= MAX_V))
               w_state_n = ST_HALT;
         end
         ST_RUN: begin
            if (w_hit && (w_cnt_inc >= MAX_V))
               w_state_n = ST_HALT;
         end
         ST_HALT: w_state_n = ST_HALT;
         default: w_state_n = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= ST_INIT;
      else
         r_state <= w_state_n;
   end

   // model keeps running from its own state, never from the DUT q
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_exp_q   <= '0;
         r_exp_rco <= 1'b0;
      end else begin
         r_exp_q   <= w_q_n;
         r_exp_rco <= w_rco_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err        <= 1'b0;
         err_sticky <= 1'b0;
         err_cnt    <= '0;
         first_exp  <= '0;
         first_got  <= '0;
      end else begin
         err <= w_hit;
         if (w_hit) begin
            err_cnt    <= w_cnt_inc;
            err_sticky <= 1'b1;
            if (!err_sticky) begin
               first_exp <= r_exp_q;
               first_got <= q;
            end
         end
      end
   end

   assign halted = (r_state == ST_HALT);

endmodule
